mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS CPU, beside the single-cycle ALU. It executes mult/multu/div/divu over a configurable number of cycles into private HI/LO registers. It also serves mthi/mtlo/mfhi/mflo, and raises `busy` so the hazard unit can stall dependent instructions. It honours the exception/interrupt flush request, so an instruction cancelled in EX never modifies HI/LO.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and HI/LO width.
- `MULT_CYCLES`, default 5: busy cycles for multiply ops; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for divide ops; must be ≥1.

**Ports**
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `start` in 1: the EX instruction is an MDU op this cycle.
- `op` in 4: operation code.
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7–10 MADD/MADDU/MSUB/MSUBU, only with the macro.
  - Any other value acts as NOP.
- `srcA` in WIDTH: rs operand.
- `srcB` in WIDTH: rt operand.
- `req` in 1: exception/interrupt flush; when high, this cycle's `start` is discarded.
- `rd_hi` in 1: read select for `result`; 1 selects HI, 0 selects LO.
- `busy` out 1: registered; high while a multi-cycle op is in flight.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `result` out WIDTH: combinational; equals `rd_hi ? hi : lo`, used for mfhi/mflo.

## Operation

**State machine: IDLE, BUSY.** Internal registers are a down-counter `cnt`, pending registers `pend_hi`/`pend_lo`, and a `pend_wr` flag.

**Accept condition:** `start & ~req & ~busy`.

**IDLE, accepted MULT/MULTU/DIV/DIVU:**
- Compute the 2·WIDTH result from the current operands and store it in `pend_hi`/`pend_lo`.
- Load `cnt` with MULT_CYCLES or DIV_CYCLES.
- Go to BUSY.
- Set `pend_wr` = 0 only for a divide with `srcB == 0`; otherwise 1.

**IDLE, accepted MTHI/MTLO:** write `srcA` to HI or LO at that same edge. No busy cycle.

**BUSY:** decrement `cnt` each edge. On the edge where `cnt` reaches 0:
- If `pend_wr`, commit `pend_hi`/`pend_lo` to HI/LO.
- Return to IDLE.

**Arithmetic rules:**
- MULT: signed WIDTH×WIDTH → 2·WIDTH. HI = upper half, LO = lower half.
- MULTU: unsigned, same split.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Signed MIN / −1: LO = MIN, HI = 0.
- Divide by zero: HI and LO keep their old values, but busy still lasts DIV_CYCLES.

**Boundary rules:**
- `start` while BUSY is ignored. The hazard unit guarantees this by stalling on `busy | (start & multi-cycle op)`.
- `req` while BUSY does not abort; the issued op completes, matching MIPS semantics.
- `req` with `start` in the same cycle: no state change.
- Reset mid-operation: busy = 0, HI = LO = 0, `cnt` = 0, FSM = IDLE; the pending result is discarded.

## Timing

- **Reset values:** `busy` = 0, `hi` = 0, `lo` = 0. `result` = 0 because it is derived from HI/LO.
- **Multi-cycle op accepted at edge T:**
  - `busy` is high for exactly N cycles, from after T up to edge T+N.
  - HI/LO update at edge T+N, and `busy` falls at that same edge.
  - An mfhi in the next cycle reads the new value.
- **MTHI/MTLO:** latency 1 edge; `busy` stays 0.
- **Reads:** `result` follows HI/LO and `rd_hi` combinationally, with no added latency.

## Configuration

- **Macro `MDU_MADD_EN`, defined:** ops 7–10 are legal.
  - Multiply-accumulate latency is MULT_CYCLES.
  - At acceptance, `pend` = {HI,LO} ± product. MADD/MSUB use signed operands; MADDU/MSUBU use unsigned.
  - The ± is computed modulo 2^(2·WIDTH), using the HI/LO values present at acceptance.
- **Macro undefined:** ops 7–10 decode as NOP; no accumulator adder is synthesised.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle → `busy`, `hi`, `lo` = 0 immediately, without waiting for a clock.
- **MULT:** `srcA` = 0xFFFFFFFF, `srcB` = 2, default parameters → `busy` high for 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- **DIV:**
  - −7 / 2 → after 10 busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 0 → HI/LO unchanged after 10 busy cycles.
- **Flush interaction:**
  - MULT with `req` = 1 in the same cycle → `busy` stays 0, HI/LO unchanged.
  - `req` pulse during BUSY → result still commits.
- **Back-to-back and move ops:**
  - MTLO 0x1234 → `lo` = 0x1234 next edge.
  - `start` with MULT during BUSY is ignored.
  - `rd_hi` = 0 → `result` = 0x1234.
- **MADD (`MDU_MADD_EN` defined):** HI:LO = 0:1, MADD 3×4 → after 5 cycles LO = 13, HI = 0.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with private HI/LO registers.
// The result of mult/multu/div/divu is computed at acceptance and held in
// pend_hi/pend_lo. It is committed to HI/LO when the busy countdown expires.
// mthi/mtlo write at the accepting edge. result is a combinational mfhi/mflo read.
// Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 7-10).
module mdu_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             req,
   input  logic             rd_hi,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAXC + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;
   logic             accept;

   // Magnitude of an operand, treating it as two's complement when sgn is set.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   // Conditional two's-complement negation used to restore quotient/remainder sign.
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] prod_u;
   logic                      div_sgn;
   logic        [WIDTH-1:0]   mag_a, mag_b, div_b, q_u, r_u, quot, rem;

   assign prod_s  = $signed({{WIDTH{srcA[WIDTH-1]}}, srcA}) *
                    $signed({{WIDTH{srcB[WIDTH-1]}}, srcB});
   assign prod_u  = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};

   // Signed divide runs on magnitudes; MIN / -1 wraps naturally to LO = MIN, HI = 0.
   assign div_sgn = (op == OP_DIV);
   assign mag_a   = mag(srcA, div_sgn);
   assign mag_b   = mag(srcB, div_sgn);
   assign div_b   = (srcB == '0) ? WIDTH'(1) : mag_b;
   assign q_u     = mag_a / div_b;
   assign r_u     = mag_a % div_b;
   assign quot    = neg_if(q_u, div_sgn && (srcA[WIDTH-1] ^ srcB[WIDTH-1]));
   assign rem     = neg_if(r_u, div_sgn && srcA[WIDTH-1]);

`ifdef MDU_MADD_EN
   logic [2*WIDTH-1:0] acc;
   assign acc = {hi_q, lo_q};
`endif

   assign accept = start && !req && (state_q == IDLE);
   assign busy   = (state_q == BUSY);
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign result = rd_hi ? hi_q : lo_q;

   // Next-state logic: op acceptance in IDLE, countdown and commit in BUSY.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT: begin
                     {pend_hi_d, pend_lo_d} = prod_s;
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = BUSY;
                  end
                  OP_MULTU: begin
                     {pend_hi_d, pend_lo_d} = prod_u;
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_d = rem;
                     pend_lo_d = quot;
                     pend_wr_d = (srcB != '0);
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = BUSY;
                  end
                  OP_MTHI: hi_d = srcA;
                  OP_MTLO: lo_d = srcA;
`ifdef MDU_MADD_EN
                  OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                     case (op)
                        OP_MADD:  {pend_hi_d, pend_lo_d} = acc + prod_s;
                        OP_MADDU: {pend_hi_d, pend_lo_d} = acc + prod_u;
                        OP_MSUB:  {pend_hi_d, pend_lo_d} = acc - prod_s;
                        default:  {pend_hi_d, pend_lo_d} = acc - prod_u;
                     endcase
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = BUSY;
                  end
`endif
                  default: ;
               endcase
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and architectural state; reset cancels any op in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Pending result data; only meaningful while pend_wr_q is set in BUSY.
   always_ff @(posedge clk) begin
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
   end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized and directed bench for mdu_unit against an
// arithmetic reference model of HI/LO (MDU_MADD_EN honoured if defined).
module tb_mdu_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] srcA = '0, srcB = '0;
   logic        req = 1'b0;
   logic        rd_hi = 1'b0;
   logic        busy;
   logic [31:0] hi, lo, result;

   logic [31:0] mdl_hi = '0, mdl_lo = '0;
   int n_vec = 0;
   int n_err = 0;

   mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
      .req(req), .rd_hi(rd_hi), .busy(busy), .hi(hi), .lo(lo), .result(result)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: new HI/LO and busy length for one issued op.
   task automatic model_op(input logic [3:0] o, input logic [31:0] a, b, input logic r,
                           output int n, output logic [31:0] nh, nl);
      longint sa, sb, q, rm;
      longint unsigned ua, ub;
      logic [63:0] p;
      nh = mdl_hi; nl = mdl_lo; n = 0;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = {32'b0, a}; ub = {32'b0, b};
      if (!r) begin
         case (o)
            4'd1: begin p = sa * sb; {nh, nl} = p; n = MC; end
            4'd2: begin p = ua * ub; {nh, nl} = p; n = MC; end
            4'd3: begin
               n = DC;
               if (b != 0) begin q = sa / sb; rm = sa % sb; nl = q[31:0]; nh = rm[31:0]; end
            end
            4'd4: begin
               n = DC;
               if (b != 0) begin nl = a / b; nh = a % b; end
            end
            4'd5: nh = a;
            4'd6: nl = a;
`ifdef MDU_MADD_EN
            4'd7:  begin p = {mdl_hi, mdl_lo} + 64'(sa * sb); {nh, nl} = p; n = MC; end
            4'd8:  begin p = {mdl_hi, mdl_lo} + 64'(ua * ub); {nh, nl} = p; n = MC; end
            4'd9:  begin p = {mdl_hi, mdl_lo} - 64'(sa * sb); {nh, nl} = p; n = MC; end
            4'd10: begin p = {mdl_hi, mdl_lo} - 64'(ua * ub); {nh, nl} = p; n = MC; end
`endif
            default: ;
         endcase
      end
   endtask

   // Issue one op; disturb 1 = stray MULT while busy, 2 = req pulse while busy.
   task automatic do_op(input logic [3:0] o, input logic [31:0] a, b, input logic r,
                        input int disturb);
      int n;
      logic [31:0] nh, nl;
      model_op(o, a, b, r, n, nh, nl);
      @(negedge clk);
      start = 1'b1; op = o; srcA = a; srcB = b; req = r;
      @(posedge clk); #1;
      start = 1'b0; op = 4'd0; req = 1'b0; srcA = $urandom; srcB = $urandom;
      for (int k = 0; k < n; k++) begin
         chk("busy_during", busy, 1);
         chk("hi_hold", hi, mdl_hi);
         chk("lo_hold", lo, mdl_lo);
         if (k == 1 && disturb == 1) begin start = 1'b1; op = 4'd1; srcA = 3; srcB = 3; end
         if (k == 1 && disturb == 2) req = 1'b1;
         @(posedge clk); #1;
         start = 1'b0; op = 4'd0; req = 1'b0;
      end
      chk("busy_after", busy, 0);
      mdl_hi = nh; mdl_lo = nl;
      chk("hi", hi, mdl_hi);
      chk("lo", lo, mdl_lo);
      rd_hi = 1'($urandom);
      #1;
      chk("result", result, rd_hi ? mdl_hi : mdl_lo);
   endtask

   initial begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      logic        rr;

      // Asynchronous reset before any clock edge
      #1 reset = 1'b1;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_result", result, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // Directed cases
      do_op(4'd6, 32'h1234, 32'h0, 1'b0, 0);
      rd_hi = 1'b0; #1 chk("mflo", result, 32'h1234);
      do_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFFE);
      do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 2);
      chk("div_lo", lo, 32'hFFFFFFFD);
      chk("div_hi", hi, 32'hFFFFFFFF);
      do_op(4'd4, 32'd7, 32'd0, 1'b0, 0);
      chk("divz_lo", lo, 32'hFFFFFFFD);
      do_op(4'd1, 32'd100, 32'd100, 1'b1, 0);
      chk("flush_lo", lo, 32'hFFFFFFFD);
      do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
      chk("minneg_lo", lo, 32'h80000000);
      chk("minneg_hi", hi, 32'h0);
      do_op(4'd5, 32'hCAFE0001, 32'h0, 1'b0, 0);
      do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
      do_op(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 0);

`ifdef MDU_MADD_EN
      do_op(4'd5, 32'd0, 32'd0, 1'b0, 0);
      do_op(4'd6, 32'd1, 32'd0, 1'b0, 0);
      do_op(4'd7, 32'd3, 32'd4, 1'b0, 0);
      chk("madd_lo", lo, 32'd13);
      chk("madd_hi", hi, 32'd0);
`endif

      // Randomized ops
      for (int i = 0; i < 60; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 4) == 0) rb = 32'd0;
         if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
         rr = ($urandom_range(0, 7) == 0);
         do_op(ro, ra, rb, rr, int'($urandom_range(0, 2)));
      end

      // Reset in the middle of a multiply discards the pending result
      do_op(4'd5, 32'h55, 32'h0, 1'b0, 0);
      @(negedge clk);
      start = 1'b1; op = 4'd1; srcA = 32'd7; srcB = 32'd9;
      @(posedge clk); #1;
      start = 1'b0; op = 4'd0;
      chk("mid_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_hi", hi, 0);
      chk("mid_rst_lo", lo, 0);
      @(negedge clk) reset = 1'b0;
      mdl_hi = '0; mdl_lo = '0;
      repeat (MC + 2) @(posedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_hi", hi, 0);
      chk("post_rst_lo", lo, 0);
      do_op(4'd2, 32'd6, 32'd7, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
